// File: rtl/iob_spi_fl_arb_pkg.sv
// iob_spi_fl_arb_pkg: shared encodings for the SPI flash controller arbiter.
// Holds the grant FSM state encoding, the requester/grant encoding and the
// bit offsets of the FL_* command and command-type words. These offsets are
// shared with the SPI peripheral register map.
package iob_spi_fl_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GRANT_NONE  = 2'd0,
        GRANT_CACHE = 2'd1,
        GRANT_SW    = 2'd2
    } grant_t;

    // Command word layout: opcode[7:0], nbits[14:8], dummy[19:16]
    localparam int CMD_OPCODE_LSB  = 0;
    localparam int CMD_NBITS_LSB   = 8;
    localparam int CMD_DUMMY_LSB   = 16;

    // Command type word layout: commtype[2:0]
    localparam int TP_COMMTYPE_LSB = 0;

    // Builds a command word with frame/xip left at zero
    function automatic logic [31:0] make_command(
        input logic [7:0] opcode,
        input logic [6:0] nbits,
        input logic [3:0] dummy
    );
        logic [31:0] word;
        word = '0;
        word[CMD_OPCODE_LSB +: 8] = opcode;
        word[CMD_NBITS_LSB  +: 7] = nbits;
        word[CMD_DUMMY_LSB  +: 4] = dummy;
        return word;
    endfunction

    // Builds a command type word with dtr/4B/spimode left at zero
    function automatic logic [31:0] make_commandtp(input logic [2:0] commtype);
        logic [31:0] word;
        word = '0;
        word[TP_COMMTYPE_LSB +: 3] = commtype;
        return word;
    endfunction

endpackage

// File: rtl/iob_spi_fl_arb_sel.sv
// iob_spi_fl_arb_sel: combinational winner select for the flash arbiter.
// With SPI_FL_ARB_RR_EN defined, conflicts go to the requester that did not
// win last time; otherwise the cache always wins a conflict and no history
// input exists.
module iob_spi_fl_arb_sel
    import iob_spi_fl_arb_pkg::*;
(
    input  logic   c_valid,
    input  logic   s_valid,
`ifdef SPI_FL_ARB_RR_EN
    input  grant_t last,
`endif
    output grant_t winner
);

    // Pick a single winner among the currently valid requesters
    always_comb begin
        winner = GRANT_NONE;
        if (c_valid && s_valid) begin
`ifdef SPI_FL_ARB_RR_EN
            winner = (last == GRANT_CACHE) ? GRANT_SW : GRANT_CACHE;
`else
            winner = GRANT_CACHE;
`endif
        end else if (c_valid) begin
            winner = GRANT_CACHE;
        end else if (s_valid) begin
            winner = GRANT_SW;
        end
    end

endmodule

// File: rtl/iob_spi_fl_arbiter.sv
// iob_spi_fl_arbiter: shares one spi_master_fl controller between the
// instruction-cache read port and the CPU software command port.
// A granted request is latched into the fl_* holding registers, started with
// a one-cycle fl_valid, and the controller result is returned to the winner
// with a one-cycle ready pulse. Optional macro SPI_FL_ARB_RR_EN switches
// conflict resolution from fixed cache priority to round-robin.
module iob_spi_fl_arbiter
    import iob_spi_fl_arb_pkg::*;
#(
    parameter int          ADDR_W      = 24,
    parameter int          DATA_W      = 32,
    parameter logic [7:0]  CACHE_CMD   = 8'h0B,
    parameter logic [2:0]  CACHE_CMDTP = 3'd1,
    parameter logic [3:0]  CACHE_DUMMY = 4'd8,
    parameter logic [6:0]  CACHE_NBITS = 7'd32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_valid,
    input  logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_ready,
    input  logic              s_valid,
    input  logic [31:0]       s_addr,
    input  logic [31:0]       s_command,
    input  logic [31:0]       s_commandtp,
    output logic [DATA_W-1:0] s_rdata,
    output logic              s_ready,
    output logic              fl_valid,
    output logic [31:0]       fl_address,
    output logic [31:0]       fl_command,
    output logic [31:0]       fl_commandtp,
    input  logic [DATA_W-1:0] fl_rdata,
    input  logic              fl_ready,
    output logic              busy
);

    state_t state;
    grant_t grant;
    grant_t winner;
`ifdef SPI_FL_ARB_RR_EN
    grant_t last;
`endif

    iob_spi_fl_arb_sel u_sel (
        .c_valid (c_valid),
        .s_valid (s_valid),
`ifdef SPI_FL_ARB_RR_EN
        .last    (last),
`endif
        .winner  (winner)
    );

    // Grant FSM: latch the winner's request, pulse fl_valid, wait for the
    // controller, then pulse the winner's ready; all outputs are registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            grant        <= GRANT_NONE;
`ifdef SPI_FL_ARB_RR_EN
            last         <= GRANT_SW;
`endif
            fl_valid     <= 1'b0;
            c_ready      <= 1'b0;
            s_ready      <= 1'b0;
            busy         <= 1'b0;
            fl_address   <= '0;
            fl_command   <= '0;
            fl_commandtp <= '0;
            c_rdata      <= '0;
            s_rdata      <= '0;
        end else begin
            fl_valid <= 1'b0;
            c_ready  <= 1'b0;
            s_ready  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (winner != GRANT_NONE) begin
                        grant    <= winner;
                        fl_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_ISSUE;
                        if (winner == GRANT_CACHE) begin
                            fl_address   <= 32'(c_addr);
                            fl_command   <= make_command(CACHE_CMD, CACHE_NBITS, CACHE_DUMMY);
                            fl_commandtp <= make_commandtp(CACHE_CMDTP);
                        end else begin
                            fl_address   <= s_addr;
                            fl_command   <= s_command;
                            fl_commandtp <= s_commandtp;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (fl_ready) begin
                        if (grant == GRANT_CACHE) begin
                            c_rdata <= fl_rdata;
                            c_ready <= 1'b1;
                        end else begin
                            s_rdata <= fl_rdata;
                            s_ready <= 1'b1;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
`ifdef SPI_FL_ARB_RR_EN
                    last  <= grant;
`endif
                    grant <= GRANT_NONE;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_spi_fl_arbiter.sv
// tb_iob_spi_fl_arbiter: directed self-checking bench for iob_spi_fl_arbiter.
// A small flash controller model answers each fl_valid after a programmable
// delay; a monitor counts fl_valid and ready pulses on the falling edge.
// Expectations for SPI_FL_ARB_RR_EN follow the same macro.
module tb_iob_spi_fl_arbiter;

    logic        clk;
    logic        rst;
    logic        c_valid;
    logic [23:0] c_addr;
    logic [31:0] c_rdata;
    logic        c_ready;
    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_command;
    logic [31:0] s_commandtp;
    logic [31:0] s_rdata;
    logic        s_ready;
    logic        fl_valid;
    logic [31:0] fl_address;
    logic [31:0] fl_command;
    logic [31:0] fl_commandtp;
    logic [31:0] fl_rdata;
    logic        fl_ready;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Controller model controls
    logic        model_en    = 1'b0;
    int          model_delay = 10;
    logic [31:0] model_data  = 32'h0;
    int          stray_req   = 0;
    int          stray_ack   = 0;
    logic        pending     = 1'b0;
    int          cnt         = 0;

    // Pulse counters
    int fl_valid_cnt = 0;
    int c_ready_cnt  = 0;
    int s_ready_cnt  = 0;

    iob_spi_fl_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .c_valid      (c_valid),
        .c_addr       (c_addr),
        .c_rdata      (c_rdata),
        .c_ready      (c_ready),
        .s_valid      (s_valid),
        .s_addr       (s_addr),
        .s_command    (s_command),
        .s_commandtp  (s_commandtp),
        .s_rdata      (s_rdata),
        .s_ready      (s_ready),
        .fl_valid     (fl_valid),
        .fl_address   (fl_address),
        .fl_command   (fl_command),
        .fl_commandtp (fl_commandtp),
        .fl_rdata     (fl_rdata),
        .fl_ready     (fl_ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flash controller model: fl_ready model_delay cycles after fl_valid
    always @(negedge clk) begin
        fl_ready = 1'b0;
        if (pending) begin
            if (cnt == 0) begin
                fl_ready = 1'b1;
                fl_rdata = model_data;
                pending  = 1'b0;
            end else begin
                cnt = cnt - 1;
            end
        end
        if (fl_valid && model_en) begin
            pending = 1'b1;
            cnt     = model_delay - 1;
        end
        if (stray_req != stray_ack) begin
            fl_ready  = 1'b1;
            fl_rdata  = 32'hBAD0BAD0;
            stray_ack = stray_req;
        end
    end

    // Pulse monitor
    always @(negedge clk) begin
        if (fl_valid) fl_valid_cnt++;
        if (c_ready)  c_ready_cnt++;
        if (s_ready)  s_ready_cnt++;
    end

    // Bounded wait for a ready pulse on either port
    task automatic wait_ready(input int max_cycles, output logic found, output int cycles,
                              output logic was_cache);
        found = 1'b0;
        cycles = 0;
        was_cache = 1'b0;
        for (int i = 1; i <= max_cycles; i++) begin
            @(negedge clk);
            if (c_ready || s_ready) begin
                found = 1'b1;
                cycles = i;
                was_cache = c_ready;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        c_valid = 1'b0; c_addr = '0;
        s_valid = 1'b0; s_addr = '0; s_command = '0; s_commandtp = '0;
        fl_rdata = '0; fl_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (fl_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fl_valid: got %b expected 0", fl_valid); end
        n_checks++; if (c_ready !== 1'b0 || s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got c=%b s=%b expected 0/0", c_ready, s_ready); end
        n_checks++; if (fl_command !== 32'h0 || fl_commandtp !== 32'h0 || fl_address !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_fl_words: got %h %h %h expected zeros", fl_address, fl_command, fl_commandtp); end
        n_checks++; if (c_rdata !== 32'h0 || s_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rdata: got c=%h s=%h expected 0/0", c_rdata, s_rdata); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cache_only();
        int fv0, cr0, sr0, cycles;
        logic found, was_c;
        fv0 = fl_valid_cnt; cr0 = c_ready_cnt; sr0 = s_ready_cnt;
        model_en = 1'b1; model_delay = 10; model_data = 32'hDEADBEEF;
        c_addr = 24'h000100; c_valid = 1'b1;
        wait_ready(60, found, cycles, was_c);
        n_checks++; if (found !== 1'b1 || was_c !== 1'b1) begin n_fail++; $display("[TB] FAIL cache_ready_seen: got found=%b cache=%b expected 1/1", found, was_c); end
        n_checks++; if (cycles != 12) begin n_fail++; $display("[TB] FAIL cache_latency: got %0d expected 12", cycles); end
        n_checks++; if (c_rdata !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL cache_rdata: got %h expected deadbeef", c_rdata); end
        n_checks++; if (fl_command !== 32'h0008200B) begin n_fail++; $display("[TB] FAIL cache_command: got %h expected 0008200b", fl_command); end
        n_checks++; if (fl_commandtp !== 32'h1) begin n_fail++; $display("[TB] FAIL cache_commandtp: got %h expected 1", fl_commandtp); end
        n_checks++; if (fl_address !== 32'h100) begin n_fail++; $display("[TB] FAIL cache_address: got %h expected 100", fl_address); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL cache_busy_resp: got %b expected 1", busy); end
        c_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (c_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL cache_pulse_end: got ready=%b busy=%b expected 0/0", c_ready, busy); end
        repeat (3) @(negedge clk);
        n_checks++; if (fl_valid_cnt - fv0 != 1) begin n_fail++; $display("[TB] FAIL cache_fl_valid_count: got %0d expected 1", fl_valid_cnt - fv0); end
        n_checks++; if (c_ready_cnt - cr0 != 1 || s_ready_cnt - sr0 != 0) begin n_fail++; $display("[TB] FAIL cache_ready_counts: got c=%0d s=%0d expected 1/0", c_ready_cnt - cr0, s_ready_cnt - sr0); end
    endtask

    task automatic test_sw_only();
        int cr0, cycles;
        logic found, was_c;
        cr0 = c_ready_cnt;
        model_en = 1'b1; model_delay = 3; model_data = 32'h12345678;
        s_addr = 32'h0; s_command = 32'h00001F9F; s_commandtp = 32'h40000002; s_valid = 1'b1;
        wait_ready(40, found, cycles, was_c);
        n_checks++; if (found !== 1'b1 || was_c !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_ready_seen: got found=%b cache=%b expected 1/0", found, was_c); end
        n_checks++; if (cycles != 5) begin n_fail++; $display("[TB] FAIL sw_latency: got %0d expected 5", cycles); end
        n_checks++; if (s_rdata !== 32'h12345678) begin n_fail++; $display("[TB] FAIL sw_rdata: got %h expected 12345678", s_rdata); end
        n_checks++; if (fl_command !== 32'h00001F9F || fl_commandtp !== 32'h40000002 || fl_address !== 32'h0) begin n_fail++; $display("[TB] FAIL sw_passthrough: got %h %h %h expected 00000000 00001f9f 40000002", fl_address, fl_command, fl_commandtp); end
        n_checks++; if (c_rdata !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL sw_cache_rdata_hold: got %h expected deadbeef", c_rdata); end
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (c_ready_cnt - cr0 != 0) begin n_fail++; $display("[TB] FAIL sw_no_cache_ready: got %0d expected 0", c_ready_cnt - cr0); end
    endtask

    task automatic test_conflict();
        int fv0, cycles;
        logic found, was_c;
        logic exp_c [4];
`ifdef SPI_FL_ARB_RR_EN
        exp_c = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_c = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
        fv0 = fl_valid_cnt;
        model_en = 1'b1; model_delay = 2; model_data = 32'hA5A50000;
        c_addr = 24'h000200; c_valid = 1'b1;
        s_addr = 32'h10; s_command = 32'h00002003; s_commandtp = 32'h0; s_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ready(40, found, cycles, was_c);
            n_checks++; if (found !== 1'b1 || was_c !== exp_c[k]) begin n_fail++; $display("[TB] FAIL conflict_grant_%0d: got found=%b cache=%b expected 1/%b", k, found, was_c, exp_c[k]); end
`ifndef SPI_FL_ARB_RR_EN
            if (k == 2) c_valid = 1'b0;
`endif
        end
        c_valid = 1'b0; s_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (fl_valid_cnt - fv0 != 4) begin n_fail++; $display("[TB] FAIL conflict_fl_valid_count: got %0d expected 4", fl_valid_cnt - fv0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL conflict_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_wait();
        int fv0, cr0, sr0, cycles;
        logic found, was_c;
        model_en = 1'b0; model_data = 32'h0BADF00D;
        c_addr = 24'h000300; c_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b1 || fl_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstwait_in_wait: got busy=%b fl_valid=%b expected 1/0", busy, fl_valid); end
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || c_ready !== 1'b0 || s_ready !== 1'b0 || fl_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstwait_abort: got busy=%b c=%b s=%b fv=%b expected 0/0/0/0", busy, c_ready, s_ready, fl_valid); end
        @(negedge clk);
        rst = 1'b0; c_valid = 1'b0;
        fv0 = fl_valid_cnt; cr0 = c_ready_cnt; sr0 = s_ready_cnt;
        stray_req++;
        repeat (4) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || c_ready_cnt != cr0 || s_ready_cnt != sr0 || fl_valid_cnt != fv0) begin n_fail++; $display("[TB] FAIL rstwait_late_ready: got busy=%b dc=%0d ds=%0d dfv=%0d expected 0/0/0/0", busy, c_ready_cnt - cr0, s_ready_cnt - sr0, fl_valid_cnt - fv0); end
        n_checks++; if (c_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rstwait_rdata: got %h expected 0", c_rdata); end
        model_en = 1'b1; model_delay = 4; model_data = 32'h55AA33CC;
        s_addr = 32'h400; s_command = 32'h0000200B; s_commandtp = 32'h1; s_valid = 1'b1;
        wait_ready(40, found, cycles, was_c);
        s_valid = 1'b0;
        n_checks++; if (found !== 1'b1 || was_c !== 1'b0 || s_rdata !== 32'h55AA33CC) begin n_fail++; $display("[TB] FAIL rstwait_next_req: got found=%b cache=%b rdata=%h expected 1/0/55aa33cc", found, was_c, s_rdata); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stray_and_drop();
        int fv0, cr0, sr0, cycles;
        logic found, was_c;
        fv0 = fl_valid_cnt; cr0 = c_ready_cnt; sr0 = s_ready_cnt;
        stray_req++;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || fl_valid_cnt != fv0 || c_ready_cnt != cr0 || s_ready_cnt != sr0) begin n_fail++; $display("[TB] FAIL stray_idle: got busy=%b dfv=%0d dc=%0d ds=%0d expected 0/0/0/0", busy, fl_valid_cnt - fv0, c_ready_cnt - cr0, s_ready_cnt - sr0); end
        n_checks++; if (s_rdata !== 32'h55AA33CC || c_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL stray_rdata_hold: got s=%h c=%h expected 55aa33cc/0", s_rdata, c_rdata); end
        model_en = 1'b1; model_delay = 6; model_data = 32'hCAFEF00D;
        c_addr = 24'h00ABCD; c_valid = 1'b1;
        repeat (3) @(negedge clk);
        c_valid = 1'b0;
        wait_ready(40, found, cycles, was_c);
        n_checks++; if (found !== 1'b1 || was_c !== 1'b1) begin n_fail++; $display("[TB] FAIL drop_ready: got found=%b cache=%b expected 1/1", found, was_c); end
        n_checks++; if (c_rdata !== 32'hCAFEF00D || fl_address !== 32'h0000ABCD) begin n_fail++; $display("[TB] FAIL drop_data: got rdata=%h addr=%h expected cafef00d/0000abcd", c_rdata, fl_address); end
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || fl_valid_cnt - fv0 != 1) begin n_fail++; $display("[TB] FAIL drop_single_issue: got busy=%b dfv=%0d expected 0/1", busy, fl_valid_cnt - fv0); end
    endtask

    initial begin
        $display("[TB] starting iob_spi_fl_arbiter bench");
        test_reset();
        test_cache_only();
        test_sw_only();
        test_conflict();
        test_reset_wait();
        test_stray_and_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
